// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60Hz raster constants and the coordinate type used by the timing generator.
// The sync helper returns the active-low sync level for a position against a [first, end) pulse window.
package vga_timing_pkg;

  typedef logic [9:0] coord_t;

  localparam int H_ACTIVE_D = 640;
  localparam int H_FP_D     = 16;
  localparam int H_SYNC_D   = 96;
  localparam int H_BP_D     = 48;
  localparam int H_TOTAL_D  = H_ACTIVE_D + H_FP_D + H_SYNC_D + H_BP_D;

  localparam int V_ACTIVE_D = 480;
  localparam int V_FP_D     = 10;
  localparam int V_SYNC_D   = 2;
  localparam int V_BP_D     = 33;
  localparam int V_TOTAL_D  = V_ACTIVE_D + V_FP_D + V_SYNC_D + V_BP_D;

  localparam int H_SYNC_START_D = H_ACTIVE_D + H_FP_D;
  localparam int H_SYNC_END_D   = H_SYNC_START_D + H_SYNC_D;
  localparam int V_SYNC_START_D = V_ACTIVE_D + V_FP_D;
  localparam int V_SYNC_END_D   = V_SYNC_START_D + V_SYNC_D;

  function automatic logic sync_n(input coord_t pos, input coord_t first, input coord_t last_excl);
    return !((pos >= first) && (pos < last_excl));
  endfunction

endpackage

// File: rtl/sync_delay_line.sv
// Fixed-depth shift register with asynchronous preset, used to align hs/vs with the
// renderers' registered output path. DEPTH=0 collapses to a plain wire.
module sync_delay_line #(
  parameter int                WIDTH     = 2,
  parameter int                DEPTH     = 2,
  parameter logic [WIDTH-1:0]  RESET_VAL = '1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_pipe
    logic [WIDTH-1:0] sync_p [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) sync_p[i] <= RESET_VAL;
      end else begin
        sync_p[0] <= din;
        for (int i = 1; i < DEPTH; i++) sync_p[i] <= sync_p[i-1];
      end
    end

    assign dout = sync_p[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Free-running raster timing source: pixel/line counters, visible-area flag, delayed
// active-low syncs, and a per-frame pulse plus wrapping frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE    = H_ACTIVE_D,
  parameter int H_FP        = H_FP_D,
  parameter int H_SYNC      = H_SYNC_D,
  parameter int H_BP        = H_BP_D,
  parameter int V_ACTIVE    = V_ACTIVE_D,
  parameter int V_FP        = V_FP_D,
  parameter int V_SYNC      = V_SYNC_D,
  parameter int V_BP        = V_BP_D,
  parameter int SYNC_DELAY  = 2,
  parameter int FRAME_CNT_W = 8
) (
  input  logic                   vga_clk,
  input  logic                   reset,
  output coord_t                 DrawX,
  output coord_t                 DrawY,
  output logic                   blank,
  output logic                   hs,
  output logic                   vs,
  output logic                   frame_start,
  output logic [FRAME_CNT_W-1:0] frame_count
);

  localparam int     H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int     V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam coord_t H_LAST       = coord_t'(H_TOTAL - 1);
  localparam coord_t V_LAST       = coord_t'(V_TOTAL - 1);
  localparam coord_t H_VIS        = coord_t'(H_ACTIVE);
  localparam coord_t V_VIS        = coord_t'(V_ACTIVE);
  localparam coord_t H_SYNC_FIRST = coord_t'(H_ACTIVE + H_FP);
  localparam coord_t H_SYNC_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam coord_t V_SYNC_FIRST = coord_t'(V_ACTIVE + V_FP);
  localparam coord_t V_SYNC_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

  coord_t     hc;
  coord_t     vc;
  logic       hs_raw;
  logic       vs_raw;
  logic [1:0] sync_dly;

  // frame_start fires only on the real wrap, so the (0,0) held by reset never pulses it
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      hc          <= '0;
      vc          <= '0;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      frame_start <= 1'b0;
      if (hc == H_LAST) begin
        hc <= '0;
        if (vc == V_LAST) begin
          vc          <= '0;
          frame_start <= 1'b1;
          frame_count <= frame_count + 1'b1;
        end else begin
          vc <= vc + 1'b1;
        end
      end else begin
        hc <= hc + 1'b1;
      end
    end
  end

  assign DrawX  = hc;
  assign DrawY  = vc;
  assign blank  = (hc < H_VIS) && (vc < V_VIS);
  assign hs_raw = sync_n(hc, H_SYNC_FIRST, H_SYNC_END);
  assign vs_raw = sync_n(vc, V_SYNC_FIRST, V_SYNC_END);

  // Syncs trail the undelayed coordinates by the renderers' ROM + output register latency
  sync_delay_line #(
    .WIDTH    (2),
    .DEPTH    (SYNC_DELAY),
    .RESET_VAL(2'b11)
  ) u_sync_delay (
    .clk (vga_clk),
    .rst (reset),
    .din ({hs_raw, vs_raw}),
    .dout(sync_dly)
  );

  assign hs = sync_dly[1];
  assign vs = sync_dly[0];

endmodule
